// File: rtl/nn_pkg.sv
// Shared constants and types for the feature-map pipeline: word format, layer state codes,
// pooled output geometry per layer, and the max-pool engine's FSM and index types.
package nn_pkg;

    localparam int unsigned DATSIZE = 22;
    localparam int unsigned FPSHIFT = 14;

    localparam logic [3:0] ST_READ  = 4'b0001;
    localparam logic [3:0] ST_CONV1 = 4'b0010;
    localparam logic [3:0] ST_POOL1 = 4'b0011;
    localparam logic [3:0] ST_CONV2 = 4'b0100;
    localparam logic [3:0] ST_POOL2 = 4'b0101;
    localparam logic [3:0] ST_POOL3 = 4'b0110;
    localparam logic [3:0] ST_CONV3 = 4'b0111;

    localparam int unsigned POOL1_H = 16, POOL1_W = 16, POOL1_C = 16;
    localparam int unsigned POOL2_H = 8,  POOL2_W = 8,  POOL2_C = 32;
    localparam int unsigned POOL3_H = 4,  POOL3_W = 4,  POOL3_C = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DRAIN,
        S_DONE
    } pool_state_t;

    typedef struct packed {
        logic       ok;
        logic [5:0] w_max;
        logic [5:0] h_max;
        logic [5:0] c_max;
    } pool_geom_t;

    typedef struct packed {
        logic [4:0] y;
        logic [4:0] x;
        logic [5:0] c;
    } pool_widx_t;

    // Inclusive upper indices of the pooled output volume; ok=0 for non-pool codes.
    function automatic pool_geom_t pool_geom(input logic [3:0] code);
        pool_geom_t g;
        g = '0;
        case (code)
            ST_POOL1: begin
                g.ok = 1'b1;
                g.w_max = 6'(POOL1_W - 1); g.h_max = 6'(POOL1_H - 1); g.c_max = 6'(POOL1_C - 1);
            end
            ST_POOL2: begin
                g.ok = 1'b1;
                g.w_max = 6'(POOL2_W - 1); g.h_max = 6'(POOL2_H - 1); g.c_max = 6'(POOL2_C - 1);
            end
            ST_POOL3: begin
                g.ok = 1'b1;
                g.w_max = 6'(POOL3_W - 1); g.h_max = 6'(POOL3_H - 1); g.c_max = 6'(POOL3_C - 1);
            end
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/pool_scan_ctr.sv
// Pooled-window scan counter: x fastest, then y, then c, with limits latched on load.
module pool_scan_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    input  logic [5:0] w_max,
    input  logic [5:0] h_max,
    input  logic [5:0] c_max,
    output logic [5:0] x,
    output logic [5:0] y,
    output logic [5:0] c,
    output logic       last
);

    logic [5:0] w_lim, h_lim, c_lim;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_lim <= '0;
            h_lim <= '0;
            c_lim <= '0;
            x     <= '0;
            y     <= '0;
            c     <= '0;
        end else if (load) begin
            w_lim <= w_max;
            h_lim <= h_max;
            c_lim <= c_max;
            x     <= '0;
            y     <= '0;
            c     <= '0;
        end else if (advance) begin
            if (x == w_lim) begin
                x <= '0;
                if (y == h_lim) begin
                    y <= '0;
                    c <= (c == c_lim) ? '0 : c + 6'd1;
                end else begin
                    y <= y + 6'd1;
                end
            end else begin
                x <= x + 6'd1;
            end
        end
    end

    assign last = (x == w_lim) && (y == h_lim) && (c == c_lim);

endmodule

// File: rtl/maxpool_engine.sv
// 2x2/stride-2 max-pool sequencer: reads up/down row pairs from feat_buf_pool and
// writes one signed max per window, one window every two cycles.
module maxpool_engine #(
    parameter int DATSIZE = 22
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             layer,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [5:0]             rd_y,
    output logic [5:0]             rd_x,
    output logic [5:0]             rd_c,
    output logic                   rd_updown,
    input  logic [2*DATSIZE-1:0]   rd_data,
    output logic                   wr_en,
    output logic [4:0]             wr_y,
    output logic [4:0]             wr_x,
    output logic [5:0]             wr_c,
    output logic [DATSIZE-1:0]     wr_data
);

    import nn_pkg::*;

    pool_state_t        state_q, state_d;
    pool_geom_t         geom;
    logic               accept;
    logic [5:0]         cx, cy, cc;
    logic               last;
    logic               up_cap, down_cap;
    pool_widx_t         idx1, idx2;
    logic [DATSIZE-1:0] up_max, pair_max;

    function automatic logic [DATSIZE-1:0] smax(input logic [DATSIZE-1:0] a,
                                                input logic [DATSIZE-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign geom   = pool_geom(layer);
    assign accept = (state_q == S_IDLE) && start && geom.ok;

    pool_scan_ctr u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .advance (state_q == S_DOWN),
        .w_max   (geom.w_max),
        .h_max   (geom.h_max),
        .c_max   (geom.c_max),
        .x       (cx),
        .y       (cy),
        .c       (cc),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        rd_updown = 1'b0;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_UP;
            S_UP: begin
                rd_en   = 1'b1;
                state_d = S_DOWN;
            end
            S_DOWN: begin
                rd_en     = 1'b1;
                rd_updown = 1'b1;
                state_d   = last ? S_DRAIN : S_UP;
            end
            S_DRAIN: if (wr_en) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign rd_y     = rd_en ? cy : '0;
    assign rd_x     = rd_en ? cx : '0;
    assign rd_c     = rd_en ? cc : '0;
    assign pair_max = smax(rd_data[DATSIZE-1:0], rd_data[2*DATSIZE-1:DATSIZE]);

    // up_cap/down_cap mark the cycles in which rd_data carries the upper/lower pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_cap   <= 1'b0;
            down_cap <= 1'b0;
            idx1     <= '0;
            idx2     <= '0;
            up_max   <= '0;
            wr_en    <= 1'b0;
            wr_y     <= '0;
            wr_x     <= '0;
            wr_c     <= '0;
            wr_data  <= '0;
        end else begin
            up_cap   <= (state_q == S_UP);
            down_cap <= (state_q == S_DOWN);
            if (state_q == S_UP) idx1 <= '{y: cy[4:0], x: cx[4:0], c: cc};
            if (up_cap) begin
                up_max <= pair_max;
                idx2   <= idx1;
            end
            if (down_cap) begin
                wr_en   <= 1'b1;
                wr_y    <= idx2.y;
                wr_x    <= idx2.x;
                wr_c    <= idx2.c;
                wr_data <= smax(up_max, pair_max);
            end else begin
                wr_en   <= 1'b0;
                wr_y    <= '0;
                wr_x    <= '0;
                wr_c    <= '0;
                wr_data <= '0;
            end
        end
    end

endmodule
